// File: rtl/muldiv_seq.sv
// Sequential HI/LO multiply/divide unit for the E stage: fixed-latency mult/div,
// immediate mthi/mtlo, and a combinational stall request for md-type D-stage instructions.
module muldiv_seq #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        d_uses_md,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        stall_req,
  output logic        done
);
  // state | meaning
  // IDLE  | accepting start; mthi/mtlo write immediately, mult/div latch operands
  // BUSY  | counting down the fixed latency; results commit when count reaches 1

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [1:0]    op_q;
  logic [31:0]   a_q;
  logic [31:0]   b_q;

  logic [63:0]   a_ext, b_ext, prod;
  logic          neg_a, neg_b;
  logic [31:0]   mag_a, mag_b, uq, ur, quo, rem;

  // op_q[0] selects the unsigned variant for both mult and div
  always_comb begin
    a_ext = op_q[0] ? {32'd0, a_q} : {{32{a_q[31]}}, a_q};
    b_ext = op_q[0] ? {32'd0, b_q} : {{32{b_q[31]}}, b_q};
    prod  = a_ext * b_ext;
  end

  // Signed divide on magnitudes; the overflow case falls out as 0x80000000 rem 0
  always_comb begin
    neg_a = ~op_q[0] & a_q[31];
    neg_b = ~op_q[0] & b_q[31];
    mag_a = neg_a ? (~a_q + 32'd1) : a_q;
    mag_b = neg_b ? (~b_q + 32'd1) : b_q;
    uq    = '0;
    ur    = '0;
    if (mag_b != 32'd0) begin
      uq = mag_a / mag_b;
      ur = mag_a % mag_b;
    end
    quo = (neg_a ^ neg_b) ? (~uq + 32'd1) : uq;
    rem = neg_a ? (~ur + 32'd1) : ur;
  end

  assign stall_req = d_uses_md & (busy | (start & ~op[2]));

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      hi    <= '0;
      lo    <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            case (op)
              3'd0, 3'd1, 3'd2, 3'd3: begin
                op_q  <= op[1:0];
                a_q   <= rs_val;
                b_q   <= rt_val;
                cnt   <= op[1] ? DIV_LOAD : MULT_LOAD;
                state <= BUSY;
                busy  <= 1'b1;
              end
              3'd4:    hi <= rs_val;
              3'd5:    lo <= rs_val;
              default: ;
            endcase
          end
        end
        BUSY: begin
          if (cnt == CNT_ONE) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            cnt   <= '0;
            if (!op_q[1]) begin
              hi <= prod[63:32];
              lo <= prod[31:0];
            end else if (b_q != 32'd0) begin
              hi <= rem;
              lo <= quo;
            end
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
